// File: rtl/vmode_sched.sv
// -----------------------------------------------------------------------------
// vmode_sched -- video mode change scheduler
//
// Software writes a new sync mode / resolution into shadow registers at any
// time. The change is held pending and only applied to the active mode
// outputs on the next vertical sync rising edge. After each change there is a
// guard window of GUARD_LINES horizontal sync rising edges. Writes that arrive
// during this window wait for the next frame.
//
// Parameters:
//   GUARD_LINES  ihsync rising edges held in GUARD after a change (0..15)
//   RESET_PAL    power-on sync mode (1 = 50 Hz / cpal, 0 = 60 Hz / cntsc)
//
// Ports:
//   clk        in   system clock, rising edge
//   porb       in   synchronous active-low reset
//   reg_we     in   register write strobe, one clk per write
//   reg_sel    in   0 = sync-mode register, 1 = resolution register
//   reg_din    in   [1:0] write data
//   ihsync     in   horizontal sync, clk-synchronous, active-high
//   ivsync     in   vertical sync, clk-synchronous, active-high
//   mde1       out  mono mode active
//   cpal       out  50 Hz colour timing active
//   cntsc      out  60 Hz colour timing active
//   mode_chg   out  one-clk pulse when the active mode outputs load
//   busy       out  high whenever the scheduler is not in RUN
//   frame_cnt  out  [7:0] frame counter
//
// Optional feature (macro VMODE_FRAMECNT_EN):
//   defined   -> frame_cnt counts every vsync rising edge, wrapping 255 -> 0
//   undefined -> frame_cnt is tied to 0 and no counter is built
// -----------------------------------------------------------------------------
module vmode_sched #(
    parameter int GUARD_LINES = 2,
    parameter bit RESET_PAL   = 1'b1
) (
    input  logic       clk,
    input  logic       porb,
    input  logic       reg_we,
    input  logic       reg_sel,
    input  logic [1:0] reg_din,
    input  logic       ihsync,
    input  logic       ivsync,
    output logic       mde1,
    output logic       cpal,
    output logic       cntsc,
    output logic       mode_chg,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PEND,
        ST_APPLY,
        ST_GUARD
    } state_t;

    // Guard count value on which the final hs_rise of the window lands.
    localparam logic [3:0] LP_GUARD_LAST = 4'((GUARD_LINES == 0) ? 0 : GUARD_LINES - 1);

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_ivs_q;
    logic       r_ihs_q;
    logic       w_vs_rise;
    logic       w_hs_rise;

    logic       r_sync_sh;
    logic [1:0] r_res_sh;
    logic       r_pending;
    logic       w_pend_any;
    logic [3:0] r_guard_cnt;
    logic       w_guard_done;
    logic       w_apply_take;

    logic       r_mde1;
    logic       r_cpal;
    logic       r_cntsc;
    logic       r_mode_chg;

    assign w_vs_rise = ivsync & ~r_ivs_q;
    assign w_hs_rise = ihsync & ~r_ihs_q;

    // A write on this very edge counts as pending, so leaving RUN or GUARD
    // does not lose a cycle waiting for the flag to register.
    assign w_pend_any   = r_pending | reg_we;
    assign w_guard_done = w_hs_rise && (r_guard_cnt == LP_GUARD_LAST);
    assign w_apply_take = (r_state == ST_PEND) && w_vs_rise;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, regardless of order.
    always_ff @(posedge clk) begin
        if (!porb) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps every path assigned, so no
    // latch is inferred for w_state_nxt.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_pend_any) begin
                    w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (w_vs_rise) begin
                    w_state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (GUARD_LINES == 0) begin
                    w_state_nxt = w_pend_any ? ST_PEND : ST_RUN;
                end else begin
                    w_state_nxt = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (w_guard_done) begin
                    w_state_nxt = w_pend_any ? ST_PEND : ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sync edge registers, shadows, pending flag, guard counter
    // -------------------------------------------------------------------------
    // NOTE: every register here has an explicit reset value; there is no
    // storage array, so nothing is left to power up undefined.
    always_ff @(posedge clk) begin
        if (!porb) begin
            r_ivs_q     <= 1'b0;
            r_ihs_q     <= 1'b0;
            r_sync_sh   <= RESET_PAL;
            r_res_sh    <= 2'b00;
            r_pending   <= 1'b0;
            r_guard_cnt <= 4'd0;
        end else begin
            r_ivs_q <= ivsync;
            r_ihs_q <= ihsync;

            if (reg_we) begin
                if (reg_sel) begin
                    r_res_sh <= reg_din;
                end else begin
                    r_sync_sh <= reg_din[1];
                end
            end

            // A write coincident with the applying vsync edge lands in the
            // shadow before APPLY reads it, so that write is consumed by this
            // apply and the clear takes priority.
            if (w_apply_take) begin
                r_pending <= 1'b0;
            end else if (reg_we) begin
                r_pending <= 1'b1;
            end

            if (r_state == ST_GUARD) begin
                if (w_hs_rise) begin
                    r_guard_cnt <= w_guard_done ? 4'd0 : r_guard_cnt + 4'd1;
                end
            end else begin
                r_guard_cnt <= 4'd0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Active mode outputs: loaded from the shadows during APPLY only
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!porb) begin
            r_mde1     <= 1'b0;
            r_cpal     <= RESET_PAL;
            r_cntsc    <= ~RESET_PAL;
            r_mode_chg <= 1'b0;
        end else begin
            r_mode_chg <= (r_state == ST_APPLY);
            if (r_state == ST_APPLY) begin
                // Mono resolution overrides colour timing; exactly one of the
                // three outputs is high.
                if (r_res_sh == 2'b10) begin
                    r_mde1  <= 1'b1;
                    r_cpal  <= 1'b0;
                    r_cntsc <= 1'b0;
                end else begin
                    r_mde1  <= 1'b0;
                    r_cpal  <= r_sync_sh;
                    r_cntsc <= ~r_sync_sh;
                end
            end
        end
    end

    assign mde1     = r_mde1;
    assign cpal     = r_cpal;
    assign cntsc    = r_cntsc;
    assign mode_chg = r_mode_chg;
    assign busy     = (r_state != ST_RUN);

    // -------------------------------------------------------------------------
    // Optional frame counter
    // -------------------------------------------------------------------------
`ifdef VMODE_FRAMECNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (!porb) begin
            r_frame_cnt <= 8'd0;
        end else if (w_vs_rise) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vmode_sched.sv
// -----------------------------------------------------------------------------
// tb_vmode_sched -- directed self-checking bench for vmode_sched
//
// Two instances share all inputs: u_dut uses the default GUARD_LINES=2 and
// u_dut_z uses GUARD_LINES=0. Inputs are driven and outputs sampled 1 ns after
// each rising clock edge. The optional frame counter is covered with or
// without VMODE_FRAMECNT_EN defined.
// -----------------------------------------------------------------------------
module tb_vmode_sched;

    logic       clk;
    logic       porb;
    logic       reg_we;
    logic       reg_sel;
    logic [1:0] reg_din;
    logic       ihsync;
    logic       ivsync;

    logic       mde1_a, cpal_a, cntsc_a, mode_chg_a, busy_a;
    logic [7:0] frame_cnt_a;
    logic       mde1_z, cpal_z, cntsc_z, mode_chg_z, busy_z;
    logic [7:0] frame_cnt_z;

    int errors;
    int checks;
    int exp_frames;
    int chg_cnt_z;

    vmode_sched #(.GUARD_LINES(2), .RESET_PAL(1'b1)) u_dut (
        .clk       (clk),
        .porb      (porb),
        .reg_we    (reg_we),
        .reg_sel   (reg_sel),
        .reg_din   (reg_din),
        .ihsync    (ihsync),
        .ivsync    (ivsync),
        .mde1      (mde1_a),
        .cpal      (cpal_a),
        .cntsc     (cntsc_a),
        .mode_chg  (mode_chg_a),
        .busy      (busy_a),
        .frame_cnt (frame_cnt_a)
    );

    vmode_sched #(.GUARD_LINES(0), .RESET_PAL(1'b1)) u_dut_z (
        .clk       (clk),
        .porb      (porb),
        .reg_we    (reg_we),
        .reg_sel   (reg_sel),
        .reg_din   (reg_din),
        .ihsync    (ihsync),
        .ivsync    (ivsync),
        .mde1      (mde1_z),
        .cpal      (cpal_z),
        .cntsc     (cntsc_z),
        .mode_chg  (mode_chg_z),
        .busy      (busy_z),
        .frame_cnt (frame_cnt_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_fc();
`ifdef VMODE_FRAMECNT_EN
        return exp_frames[7:0];
`else
        return 8'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (mode_chg_z) chg_cnt_z++;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic sel, input logic [1:0] din);
        reg_we  = 1'b1;
        reg_sel = sel;
        reg_din = din;
        tick();
        reg_we  = 1'b0;
        reg_din = 2'b00;
    endtask

    task automatic vs_pulse();
        ivsync = 1'b1;
        tick();
        exp_frames++;
        ivsync = 1'b0;
        tick();
    endtask

    task automatic hs_pulse();
        ihsync = 1'b1;
        tick();
        ihsync = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        porb = 1'b0;
        tick();
        porb = 1'b1;
        exp_frames = 0;
    endtask

    // Compare both instances against a single expected mode {mde1,cpal,cntsc}.
    task automatic check_mode(input string tag, input logic [2:0] exp);
        check({tag, ".a"}, {29'd0, mde1_a, cpal_a, cntsc_a}, {29'd0, exp});
        check({tag, ".z"}, {29'd0, mde1_z, cpal_z, cntsc_z}, {29'd0, exp});
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        exp_frames = 0;
        chg_cnt_z  = 0;
        porb       = 1'b0;
        reg_we     = 1'b0;
        reg_sel    = 1'b0;
        reg_din    = 2'b00;
        ihsync     = 1'b0;
        ivsync     = 1'b0;

        // ---------------- reset state ----------------
        step(3);
        porb = 1'b1;
        check_mode("rst_mode", 3'b010);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_busy_z", busy_z, 1'b0);
        check("rst_chg_a", mode_chg_a, 1'b0);
        check("rst_fc_a", frame_cnt_a, 8'd0);

        // ---------------- three idle frames ----------------
        for (int f = 0; f < 3; f++) begin
            hs_pulse();
            vs_pulse();
            check_mode("idle_mode", 3'b010);
            check("idle_busy_a", busy_a, 1'b0);
            check("idle_chg_a", mode_chg_a, 1'b0);
            check("idle_fc_a", frame_cnt_a, exp_fc());
        end

        // ---------------- mid-frame write -> 60 Hz ----------------
        step(3);
        wr(1'b0, 2'b00);
        check("w1_busy_a", busy_a, 1'b1);
        check("w1_busy_z", busy_z, 1'b1);
        step(2);
        check_mode("w1_hold", 3'b010);
        ivsync = 1'b1;
        tick();                                    // edge k
        exp_frames++;
        ivsync = 1'b0;
        check_mode("w1_k", 3'b010);
        check("w1_k_chg_a", mode_chg_a, 1'b0);
        tick();                                    // edge k+1
        check_mode("w1_k1", 3'b001);
        check("w1_k1_chg_a", mode_chg_a, 1'b1);
        check("w1_k1_chg_z", mode_chg_z, 1'b1);
        check("w1_k1_busy_a", busy_a, 1'b1);
        check("w1_k1_busy_z", busy_z, 1'b0);
        tick();
        check("w1_k2_chg_a", mode_chg_a, 1'b0);
        hs_pulse();
        check("w1_hs1_busy_a", busy_a, 1'b1);
        hs_pulse();
        check("w1_hs2_busy_a", busy_a, 1'b0);

        // ---------------- write coincident with vsync in PEND ----------------
        wr(1'b0, 2'b00);                           // enter PEND, same sync value
        step(2);
        reg_we  = 1'b1;
        reg_sel = 1'b1;
        reg_din = 2'b10;
        ivsync  = 1'b1;
        tick();                                    // edge k
        exp_frames++;
        reg_we  = 1'b0;
        reg_din = 2'b00;
        ivsync  = 1'b0;
        check_mode("co_k", 3'b001);
        tick();                                    // edge k+1
        check_mode("co_k1", 3'b100);
        check("co_k1_chg_a", mode_chg_a, 1'b1);
        wr(1'b1, 2'b00);                           // during GUARD of u_dut
        hs_pulse();
        hs_pulse();
        check("gw_busy_a", busy_a, 1'b1);
        step(3);
        check_mode("gw_hold", 3'b100);
        ivsync = 1'b1;
        tick();
        exp_frames++;
        ivsync = 1'b0;
        check_mode("gw_k", 3'b100);
        tick();
        check_mode("gw_k1", 3'b001);
        check("gw_k1_chg_a", mode_chg_a, 1'b1);
        check("gw_fc_a", frame_cnt_a, exp_fc());
        hs_pulse();
        hs_pulse();

        // ---------------- reset during GUARD ----------------
        wr(1'b1, 2'b10);
        vs_pulse();
        check_mode("rg_mono", 3'b100);
        check("rg_busy_a", busy_a, 1'b1);
        wr(1'b0, 2'b00);                           // pending write to be discarded
        do_reset();
        check_mode("rg_rst", 3'b010);
        check("rg_busy_a", busy_a, 1'b0);
        check("rg_busy_z", busy_z, 1'b0);
        check("rg_chg_a", mode_chg_a, 1'b0);
        check("rg_fc_a", frame_cnt_a, 8'd0);
        vs_pulse();
        check_mode("rg_after", 3'b010);
        check("rg_after_busy_a", busy_a, 1'b0);
        check("rg_after_chg_a", mode_chg_a, 1'b0);

        // ---------------- GUARD_LINES=0: two consecutive frames ----------------
        chg_cnt_z = 0;
        wr(1'b0, 2'b00);
        ivsync = 1'b1;
        tick();
        exp_frames++;
        ivsync = 1'b0;
        check("z1_k_chg", mode_chg_z, 1'b0);
        tick();
        check("z1_k1_chg", mode_chg_z, 1'b1);
        check("z1_k1_cntsc", cntsc_z, 1'b1);
        check("z1_k1_busy", busy_z, 1'b0);
        step(3);
        wr(1'b0, 2'b10);
        ivsync = 1'b1;
        tick();
        exp_frames++;
        ivsync = 1'b0;
        check("z2_k_cpal", cpal_z, 1'b0);
        tick();
        check("z2_k1_chg", mode_chg_z, 1'b1);
        check("z2_k1_cpal", cpal_z, 1'b1);
        step(3);
        check("z_chg_count", chg_cnt_z, 2);
        check("z_fc", frame_cnt_z, exp_fc());

        // ---------------- frame counter wrap ----------------
        do_reset();
        for (int f = 0; f < 256; f++) vs_pulse();
        check("fc_256_a", frame_cnt_a, exp_fc());
        vs_pulse();
        check("fc_257_a", frame_cnt_a, exp_fc());
`ifdef VMODE_FRAMECNT_EN
        check("fc_257_lit_a", frame_cnt_a, 8'd1);
`else
        check("fc_257_lit_a", frame_cnt_a, 8'd0);
`endif
        check("fc_257_z", frame_cnt_z, exp_fc());
        check_mode("fc_mode", 3'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vmode_sched.md
VMODE_SCHED -- requirements
Module: vmode_sched

Interface
REQ-001 SHALL have parameter: GUARD_LINES, 2, number of ihsync rising edges held in GUARD after a mode change (legal 0..15).
REQ-002 SHALL have parameter: RESET_PAL, 1, power-on sync mode (1 = 50 Hz/cpal, 0 = 60 Hz/cntsc).
REQ-003 SHALL have port: clk  in  1  system clock; one clock; all logic on rising edge.
REQ-004 SHALL have port: porb  in  1  reset; synchronous, active-low.
REQ-005 SHALL have port: reg_we  in  1  register write strobe, one clk per write.
REQ-006 SHALL have port: reg_sel  in  1  0 = sync-mode register, 1 = resolution register.
REQ-007 SHALL have port: reg_din  in  2  write data.
REQ-008 SHALL have port: ihsync  in  1  horizontal sync, clk-synchronous, active-high.
REQ-009 SHALL have port: ivsync  in  1  vertical sync, clk-synchronous, active-high.
REQ-010 SHALL have port: mde1  out  1  mono mode active.
REQ-011 SHALL have port: cpal  out  1  50 Hz colour timing active.
REQ-012 SHALL have port: cntsc  out  1  60 Hz colour timing active.
REQ-013 SHALL have port: mode_chg  out  1  one-clk pulse when active mode outputs load.
REQ-014 SHALL have port: busy  out  1  high whenever state is not RUN.
REQ-015 SHALL have port: frame_cnt  out  8  frame counter (see Configuration).

Function
REQ-016 SHALL keep shadow registers sync_sh (1 bit) and res_sh (2 bits); reg_we with reg_sel=0 loads sync_sh <= reg_din[1], with reg_sel=1 loads res_sh <= reg_din, in any state.
REQ-017 SHALL set a pending flag on every reg_we, whether or not the value differs from the active mode.
REQ-018 SHALL register ivsync and ihsync once each; vs_rise = ivsync & ~ivsync_q, hs_rise = ihsync & ~ihsync_q.
REQ-019 SHALL implement states RUN, PEND, APPLY, GUARD.
REQ-020 RUN -> PEND when pending is set.
REQ-021 PEND -> APPLY on a clk edge where vs_rise=1; pending is cleared at that edge.
REQ-022 APPLY lasts exactly one clk: mode outputs load from shadows, mode_chg=1 for that cycle, then -> GUARD.
REQ-023 GUARD counts hs_rise events; after GUARD_LINES events -> PEND if pending else RUN; with GUARD_LINES=0 APPLY exits directly to PEND/RUN.
REQ-024 Decode: res_sh=2'b10 -> mde1=1, cpal=0, cntsc=0; otherwise mde1=0, cpal=sync_sh, cntsc=~sync_sh; exactly one output high at all times.
REQ-025 Latency: vs_rise at edge k -> mode outputs and mode_chg change at edge k+1.
REQ-026 Write coincident with vs_rise in PEND: shadow update at edge k wins and is applied at k+1.
REQ-027 Write during APPLY: shadow updates, pending set, applied at a later frame; APPLY still loads pre-write shadow.
REQ-028 vs_rise in RUN, APPLY or GUARD: no mode change.
REQ-029 Writes during GUARD are held; no change until the next vs_rise after GUARD ends.

Reset
REQ-030 porb=0 at any clk edge, including mid-APPLY/GUARD: state=RUN, pending=0, guard count=0, res_sh=2'b00, sync_sh=RESET_PAL, mde1=0, cpal=RESET_PAL, cntsc=~RESET_PAL, mode_chg=0, busy=0, frame_cnt=0, edge registers=0.

Configuration
REQ-031 With VMODE_FRAMECNT_EN defined, frame_cnt SHALL increment by 1 on every vs_rise in any state and wrap 255 -> 0.
REQ-032 Without VMODE_FRAMECNT_EN, frame_cnt SHALL be constant 0 and the counter SHALL not be implemented.

Verification
REQ-033 Reset release, RESET_PAL=1: cpal=1, mde1=0, cntsc=0, busy=0, frame_cnt=0 -> no change over 3 frames without writes.
REQ-034 Write reg_sel=0, reg_din=2'b00 mid-frame -> busy=1 at next edge, cpal stays 1 until vs_rise edge k; cntsc=1, mode_chg=1 at k+1; busy=0 after 2 hs_rise.
REQ-035 Write reg_sel=1, reg_din=2'b10 coincident with vs_rise in PEND -> mde1=1 at k+1; second write reg_din=2'b00 during GUARD -> mde1 stays 1 until next frame's vs_rise+1.
REQ-036 porb=0 for one clk during GUARD with mde1=1 -> all outputs at reset values next edge; pending write discarded.
REQ-037 VMODE_FRAMECNT_EN defined, 257 vsync pulses -> frame_cnt=1; undefined -> frame_cnt=0 throughout.
REQ-038 GUARD_LINES=0, two writes in consecutive frames -> two mode_chg pulses, one per frame, each one clk after vs_rise.
